edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Watches N single-bit level inputs and detects every level change on each input with an XOR-against-previous-sample edge trigger.
- Queues one pending event per channel.
- Hands events one at a time to a single downstream consumer over a valid/ready handshake.
- Uses round-robin arbitration, so no channel can starve another when several edge triggers share one event handler.

Parameters:
- N, 4, number of input channels (2..16).
- ID_W, 2, width of the channel index; must satisfy 2**ID_W >= N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous assert, active-low; clears all state immediately.
- in  input  N  raw level inputs; each bit is already synchronous to clk.
- evt_valid  output  1  an event is presented on evt_id/evt_level.
- evt_ready  input  1  the consumer accepts the event when evt_valid && evt_ready at a clock edge.
- evt_id  output  ID_W  channel index of the presented event.
- evt_level  output  1  new level of that channel (1 = rising edge, 0 = falling edge).
- ovf  output  N  sticky per-channel overflow flags.
- ovf_clr  input  N  per-channel overflow clear strobes, one cycle each.
- busy  output  1  high when any pend bit is set or evt_valid is high.

Behaviour:
- Reset values:
  - in_d = 0, pend = 0, lvl = 0, ptr = 0.
  - evt_valid = 0, evt_id = 0, evt_level = 0, ovf = 0, busy = 0.
  - FSM = IDLE.
- Edge detect:
  - edge[i] = in[i] ^ in_d[i]; in_d <= in every cycle.
  - A channel held at 1 through reset release produces one rising event at the first clock edge.
- Capture: on edge[i], pend[i] <= 1 and lvl[i] <= in[i].
- Overflow:
  - Triggered when edge[i] occurs while pend[i] is already 1 and pend[i] is not being consumed in that same cycle.
  - Sets ovf[i] <= 1; lvl[i] is overwritten with the newest level, so the older event is lost and only the latest level is kept.
  - ovf[i] clears on ovf_clr[i]; if set and clear coincide, set wins.
- Arbitration:
  - Round-robin: search pend starting at index ptr and ascending with wrap; the first set bit wins.
  - ptr <= winner+1 (mod N) when the winner is loaded.
- FSM IDLE:
  - If pend is nonzero: load evt_id = winner, evt_level = lvl[winner], evt_valid <= 1, clear pend[winner], go to HOLD.
  - If an edge hits the winner channel in that same cycle, pend[winner] stays 1 with the new level and no overflow is flagged.
- FSM HOLD:
  - evt_id and evt_level are stable while evt_valid && !evt_ready.
  - On handshake with pend nonzero (excluding the bit being captured this cycle): load the next winner directly, giving back-to-back events with no bubble; stay in HOLD.
  - On handshake with pend zero: evt_valid <= 0, go to IDLE.
- Latency: an input change seen at clock edge k sets pend at k; evt_valid rises at edge k+1 if the output is free.
- Channels with in idle never generate events; a glitch shorter than one clock is invisible.
- Async reset mid-handshake drops all pending and presented events, with no ovf indication.
- ID_W/N mismatch (2**ID_W < N) is a configuration error; the bench does not exercise it.

Test Plan:
1. Basic single event:
   - Stimulus: N=4, evt_ready=1; in[0] rises 0->1 at t=125ns, falls at 150ns (20ns clock).
   - Required: two events, id=0 level=1 then id=0 level=0, each evt_valid 1 cycle; ovf=0; busy returns 0.
2. Round-robin fairness:
   - Stimulus: evt_ready=0; toggle in[3:0] simultaneously from 0000 to 1111; then hold evt_ready=1.
   - Required: ids presented 0,1,2,3 on consecutive cycles, all level=1, no bubble between them.
3. Round-robin pointer continuity:
   - Stimulus: after scenario 2 (ptr=0), edges on channels 2 and 1 in the same cycle.
   - Required: order 1 then 2. After one more event from id 1 alone, ptr=2; next simultaneous 0 and 3 gives order 3 then 0.
4. Overflow:
   - Stimulus: evt_ready=0, channel 1 already holding an event in HOLD; in[1] toggles 0->1->0 on two further cycles.
   - Required: ovf[1]=1 after the second change; the queued event reports level=0; ovf_clr[1] pulse returns ovf to 0.
5. Backpressure:
   - Stimulus: evt_valid=1 with id=2 level=1; evt_ready=0 for 5 cycles while other channels toggle.
   - Required: evt_id and evt_level unchanged for all 5 cycles; pending events are delivered after ready.
6. Async reset mid-operation:
   - Stimulus: rstn driven low between clock edges while evt_valid=1 and pend=1010.
   - Required: evt_valid, pend, ovf and busy go to 0 immediately (before the next clock). After release with in=0000, no events are produced.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: detects level changes on N synchronous inputs, keeps one
// pending event per channel and hands events one at a time to a single consumer
// over valid/ready, picking among pending channels in round-robin order.
module edge_event_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    in,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic            evt_level,
    output logic [N-1:0]    ovf,
    input  logic [N-1:0]    ovf_clr,
    output logic            busy
);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    state_e          state_q, state_d;

    logic [N-1:0]    in_d_q;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    lvl_q, lvl_d;
    logic [N-1:0]    ovf_q, ovf_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            evt_valid_q, evt_valid_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic            evt_level_q, evt_level_d;

    logic [N-1:0]    edge_hit;
    logic [N-1:0]    upper_mask;
    logic [N-1:0]    pend_upper;
    logic [ID_W-1:0] win_idx;
    logic            load;
    logic [N-1:0]    consume;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    // XOR against the previous sample flags every level change.
    assign edge_hit = in ^ in_d_q;

    // Round-robin pick: lowest pending index at or above ptr, else wrap to the
    // lowest pending index overall. Only already-registered pend bits compete.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (i >= int'(ptr_q));
        end
        pend_upper = pend_q & upper_mask;
        if (|pend_upper) begin
            win_idx = lowest_set(pend_upper);
        end else begin
            win_idx = lowest_set(pend_q);
        end
    end

    // Handshake FSM: decides when a new winner is loaded into the output slot.
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_level_d = evt_level_q;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    load    = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // Output is frozen until the consumer takes it.
                if (evt_ready) begin
                    if (|pend_q) begin
                        load = 1'b1;  // back-to-back, no bubble
                    end else begin
                        evt_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            evt_valid_d = 1'b1;
            evt_id_d    = win_idx;
            evt_level_d = lvl_q[win_idx];
        end
    end

    // Pointer advances past the winner whenever a winner is loaded.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            if (win_idx == ID_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + ID_W'(1);
            end
        end
    end

    // Pending/level/overflow bookkeeping per channel.
    always_comb begin
        consume = '0;
        for (int i = 0; i < N; i++) begin
            consume[i] = load && (win_idx == ID_W'(i));
        end
        // A fresh edge on the channel being consumed re-arms it without overflow.
        pend_d = edge_hit | (pend_q & ~consume);
        lvl_d  = (edge_hit & in) | (~edge_hit & lvl_q);
        // Overflow set dominates a coincident clear.
        ovf_d  = (edge_hit & pend_q & ~consume) | (ovf_q & ~ovf_clr);
    end

    // Input history register for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_d_q <= '0;
        end else begin
            in_d_q <= in;
        end
    end

    // Per-channel pending, captured level and sticky overflow state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
            lvl_q  <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            lvl_q  <= lvl_d;
            ovf_q  <= ovf_d;
        end
    end

    // FSM state and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Registered output event slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_level_q <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_level_q <= evt_level_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_level = evt_level_q;
    assign ovf       = ovf_q;
    assign busy      = (|pend_q) | evt_valid_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares on every accepted handshake.
module tb_edge_event_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned ID_W = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            lvl;
    } exp_t;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    in_vec;
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_level;
    logic [N-1:0]    ovf;
    logic [N-1:0]    ovf_clr;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp_e;

    edge_event_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in_vec),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_level (evt_level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got id=%0d level=%0b required none",
                         evt_id, evt_level);
            end else begin
                exp_e = exp_q.pop_front();
                if (evt_id !== exp_e.id || evt_level !== exp_e.lvl) begin
                    errors++;
                    $display("FAIL event: got id=%0d level=%0b required id=%0d level=%0b",
                             evt_id, evt_level, exp_e.id, exp_e.lvl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100us");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int id, input logic lvl);
        exp_t e;
        e.id  = ID_W'(id);
        e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        repeat (2) tick();
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain_%s: got pending=%0d busy=%0b required pending=0 busy=0",
                     name, exp_q.size(), busy);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        in_vec    = '0;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        repeat (2) tick();

        // Reset state
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id",    32'(evt_id),    0);
        check("rst_level", 32'(evt_level), 0);
        check("rst_ovf",   32'(ovf),       0);
        check("rst_busy",  32'(busy),      0);

        // Channel held high through reset release gives one rising event
        in_vec    = 4'b1000;
        evt_ready = 1'b1;
        push(3, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        wait_drain("held_high");

        // 1: basic single channel rise then fall
        in_vec[0] = 1'b1;
        push(0, 1'b1);
        tick();
        in_vec[0] = 1'b0;
        push(0, 1'b0);
        wait_drain("basic");
        check("basic_ovf",   32'(ovf),       0);
        check("basic_busy",  32'(busy),      0);
        check("basic_valid", 32'(evt_valid), 0);
        in_vec[3] = 1'b0;  // ptr returns to 0
        push(3, 1'b0);
        wait_drain("ch3_fall");

        // 2: all four rise together, delivered 0..3 back-to-back
        evt_ready = 1'b0;
        in_vec    = 4'b1111;
        for (int i = 0; i < 4; i++) push(i, 1'b1);
        repeat (3) tick();
        check("rr_first_id", 32'(evt_id), 0);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("rr_no_bubble", 32'(evt_valid), 1);
        end
        @(negedge clk);
        #1;
        check("rr_done_valid", 32'(evt_valid), 0);
        wait_drain("rr");

        // 3: pointer continuity
        tick();
        in_vec = 4'b1001;  // ch1, ch2 fall together
        push(1, 1'b0);
        push(2, 1'b0);
        wait_drain("rr_12");
        in_vec = 4'b1011;  // ch1 alone, ptr ends at 2
        push(1, 1'b1);
        wait_drain("rr_1");
        in_vec = 4'b0010;  // ch0, ch3 together: 3 first
        push(3, 1'b0);
        push(0, 1'b0);
        wait_drain("rr_30");

        // 4: overflow on channel 1 while its event is held
        evt_ready = 1'b0;
        in_vec    = 4'b0000;
        push(1, 1'b0);
        tick();
        tick();
        check("ovf_hold_id", 32'(evt_id), 1);
        in_vec[1] = 1'b1;
        tick();
        check("ovf_first_change", 32'(ovf), 0);
        in_vec[1] = 1'b0;
        push(1, 1'b0);
        tick();
        check("ovf_set", 32'(ovf), 32'h2);
        evt_ready = 1'b1;
        wait_drain("ovf");
        check("ovf_sticky", 32'(ovf), 32'h2);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        check("ovf_clear", 32'(ovf), 0);

        // 5: backpressure holds id=2 level=1 stable
        evt_ready = 1'b0;
        in_vec    = 4'b0100;
        push(2, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(evt_valid), 1);
            check("bp_id",    32'(evt_id),    2);
            check("bp_level", 32'(evt_level), 1);
            if (k == 0) in_vec[0] = 1'b1;
            if (k == 1) in_vec[3] = 1'b1;
            tick();
        end
        push(3, 1'b1);
        push(0, 1'b1);
        evt_ready = 1'b1;
        wait_drain("bp");

        // 6: async reset with an event presented and pend=1010
        evt_ready = 1'b0;
        in_vec    = 4'b1100;
        tick();
        tick();
        in_vec = 4'b0110;
        tick();
        check("pre_rst_valid", 32'(evt_valid), 1);
        check("pre_rst_busy",  32'(busy),      1);
        #3;
        rstn = 1'b0;
        #1;
        check("async_valid", 32'(evt_valid), 0);
        check("async_busy",  32'(busy),      0);
        check("async_ovf",   32'(ovf),       0);
        check("async_id",    32'(evt_id),    0);
        in_vec = 4'b0000;
        @(negedge clk);
        rstn      = 1'b1;
        evt_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_valid", 32'(evt_valid), 0);
        check("post_rst_busy",  32'(busy),      0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
